alu_mc: RTL and testbench

ALU_MC -- requirements
Module: alu_mc

---
 rtl/alu_mc.sv | 171 +++++++++++++++++
 tb/tb_alu_mc.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/alu_mc.sv
// Multi-cycle ALU with a valid/ready handshake on both sides and registered result and flags.
// Optional iterative shift-add multiplier (opcode 10) is compiled in when ALU_MC_MUL_EN is defined.
module alu_mc #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] A,
    input  logic signed [WIDTH-1:0] B,
    input  logic [3:0]              ALUControl,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        Result,
    output logic                    V,
    output logic                    N,
    output logic                    Zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             v_q, v_d;
    logic             n_q, n_d;
    logic             zero_q, zero_d;
    logic [WIDTH:0]   eval;

    // Single-cycle operations; returns {overflow, result}.
    function automatic logic [WIDTH:0] alu_eval(input logic [3:0]       op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] res;
        logic             ovf;
        logic [SHW-1:0]   sh;
        res = '0;
        ovf = 1'b0;
        sh  = b[SHW-1:0];
        case (op)
            4'd0: begin
                res = a + b;
                ovf = (a[WIDTH-1] == b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
            end
            4'd1: begin
                res = a - b;
                ovf = (a[WIDTH-1] != b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
            end
            4'd2: res = a & b;
            4'd3: res = a | b;
            4'd4: res = a ^ b;
            4'd5: res = a << sh;
            4'd6: res = a >> sh;
            4'd7: res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            4'd8: res = $signed(a) >>> sh;
            4'd9: res = {{(WIDTH-1){1'b0}}, (a < b)};
            default: res = '0;
        endcase
        return {ovf, res};
    endfunction

    assign eval = alu_eval(ALUControl, A, B);

`ifdef ALU_MC_MUL_EN
    logic             start_mul;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [SHW-1:0]   cnt_q, cnt_d;

    assign start_mul = (ALUControl == 4'd10);
`endif

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        v_d      = v_q;
        n_d      = n_q;
        zero_d   = zero_q;
`ifdef ALU_MC_MUL_EN
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d  = DONE;
                    result_d = eval[WIDTH-1:0];
                    v_d      = eval[WIDTH];
                    n_d      = eval[WIDTH-1];
                    zero_d   = (eval[WIDTH-1:0] == '0);
`ifdef ALU_MC_MUL_EN
                    if (start_mul) begin
                        state_d  = BUSY;
                        mcand_d  = A;
                        mplier_d = B;
                        acc_d    = '0;
                        cnt_d    = '0;
                    end
`endif
                end
            end
`ifdef ALU_MC_MUL_EN
            // One multiplier bit per cycle; the multiplicand walks left as the multiplier walks right.
            BUSY: begin
                acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + SHW'(1);
                if (cnt_q == SHW'(WIDTH - 1)) begin
                    state_d  = DONE;
                    cnt_d    = '0;
                    result_d = acc_d;
                    v_d      = 1'b0;
                    n_d      = acc_d[WIDTH-1];
                    zero_d   = (acc_d == '0);
                end
            end
`endif
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            result_q <= '0;
            v_q      <= 1'b0;
            n_q      <= 1'b0;
            zero_q   <= 1'b1;
`ifdef ALU_MC_MUL_EN
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            v_q      <= v_d;
            n_q      <= n_d;
            zero_q   <= zero_d;
`ifdef ALU_MC_MUL_EN
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign Result    = result_q;
    assign V         = v_q;
    assign N         = n_q;
    assign Zero      = zero_q;

endmodule

// File: tb/tb_alu_mc.sv
// Randomized self-checking bench for alu_mc (WIDTH=32) against an arithmetic reference model.
module tb_alu_mc;
    localparam int W = 32;
`ifdef ALU_MC_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic [3:0]   ALUControl = '0;
    logic         in_ready, out_valid, V, N, Zero;
    logic [W-1:0] Result;

    int n_checks = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    alu_mc #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .ALUControl(ALUControl), .out_valid(out_valid),
        .out_ready(out_ready), .Result(Result), .V(V), .N(N), .Zero(Zero)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference: results from signed/unsigned integer arithmetic in 64 bits.
    function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic v);
        longint sa, sb, s;
        int     ia;
        int     sh;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ia = int'(a);
        sh = int'(b % 32);
        r  = '0;
        v  = 1'b0;
        case (op)
            4'd0: begin s = sa + sb; r = s[31:0]; v = (s > SMAX) || (s < SMIN); end
            4'd1: begin s = sa - sb; r = s[31:0]; v = (s > SMAX) || (s < SMIN); end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = a << sh;
            4'd6: r = a >> sh;
            4'd7: r = (sa < sb) ? 32'd1 : 32'd0;
            4'd8: r = ia >>> sh;
            4'd9: r = (a < b) ? 32'd1 : 32'd0;
            4'd10: begin
                if (MUL_EN) begin s = sa * sb; r = s[31:0]; end
            end
            default: r = '0;
        endcase
    endfunction

    function automatic logic [31:0] rnd_opnd();
        case ($urandom_range(0, 6))
            0: return 32'h0;
            1: return 32'h7FFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'hFFFF_FFFF;
            4: return 32'($urandom_range(0, 40));
            default: return 32'($urandom);
        endcase
    endfunction

    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input int hold);
        logic [31:0] er, r0;
        logic        ev, stable;
        logic [2:0]  f0;
        int          exp_lat, lat, low_cnt;
        model(op, a, b, er, ev);
        exp_lat = (MUL_EN && op == 4'd10) ? W + 1 : 1;
        lat = 0;
        while (!in_ready && lat < 100) begin @(posedge clk); #1; lat++; end
        check("ready_before_op", 64'(in_ready), 64'd1);
        A = a; B = b; ALUControl = op; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; A = $urandom; B = $urandom; ALUControl = 4'($urandom);
        lat = 1;
        low_cnt = 0;
        while (!out_valid && lat < 100) begin
            if (!in_ready) low_cnt++;
            in_valid = 1'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 64'(lat), 64'(exp_lat));
        check("busy_cycles", 64'(low_cnt), 64'(exp_lat - 1));
        check("result", 64'(Result), 64'(er));
        check("flag_v", 64'(V), 64'(ev));
        check("flag_n", 64'(N), 64'(er[31]));
        check("flag_zero", 64'(Zero), 64'(er == 32'd0));
        r0 = Result;
        f0 = {V, N, Zero};
        stable = 1'b1;
        repeat (hold) begin
            in_valid = 1'($urandom);
            A = $urandom;
            ALUControl = 4'($urandom);
            @(posedge clk); #1;
            if (Result !== r0 || {V, N, Zero} !== f0 || out_valid !== 1'b1 || in_ready !== 1'b0)
                stable = 1'b0;
        end
        in_valid = 1'b0;
        check("hold_stable", 64'(stable), 64'd1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("release_to_idle", 64'({out_valid, in_ready}), 64'b01);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic seen;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_result", 64'(Result), 64'd0);
        check("rst_flags_vnz", 64'({V, N, Zero}), 64'b001);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);

        do_op(4'd0, 32'h7FFF_FFFF, 32'd1, 0);
        do_op(4'd7, 32'h8000_0000, 32'd1, 0);
        do_op(4'd9, 32'h8000_0000, 32'd1, 0);
        do_op(4'd8, 32'hF000_0000, 32'h24, 0);
        do_op(4'd6, 32'hF000_0000, 32'h24, 0);
        do_op(4'd10, 32'hFFFF_FFFD, 32'd7, 0);
        do_op(4'd1, 32'h8000_0000, 32'd1, 2);
        do_op(4'd1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 0);
        do_op(4'd13, 32'h1234_5678, 32'h9ABC_DEF0, 1);
        do_op(4'd0, 32'd10, 32'd20, 5);

        // Abort an in-flight operation with an asynchronous reset.
        A = MUL_EN ? 32'h0001_0003 : 32'd7;
        B = 32'd5;
        ALUControl = MUL_EN ? 4'd10 : 4'd0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_result", 64'(Result), 64'd0);
        check("abort_zero", 64'(Zero), 64'd1);
        #2;
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check("abort_no_result", 64'(seen), 64'd0);
        check("abort_in_ready", 64'(in_ready), 64'd1);
        do_op(4'd0, 32'd2, 32'd3, 0);

        for (int i = 0; i < 80; i++) begin
            do_op(4'($urandom_range(0, 15)), rnd_opnd(), rnd_opnd(), int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
